// File: rtl/relax_freq_pkg.sv
// Shared types and default timing constants for the relaxation-oscillator frequency meter.
package relax_freq_pkg;

  typedef enum logic [1:0] {IDLE, ARM, GATE} meter_state_t;

  localparam int DEF_CLK_REF     = 50_000_000;
  localparam int DEF_GATE_CYCLES = 50_000;
  localparam int DEF_MIN_EDGES   = 2;

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a rising-edge pulse, advanced on clk_en only.
module sig_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic sig_in,
  output logic rise_p
);

  // [0],[1] form the synchronizer; [2] is the previous synchronized value for edge detect
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = sync_q;
    if (clk_en) sync_d = {sync_q[1:0], sig_in};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign rise_p = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/relax_freq_meter.sv
// Gated edge counter: counts sig_in rising edges over back-to-back windows of GATE_CYCLES
// clk_en cycles and publishes the count scaled to Hz with a one-clock valid strobe.
module relax_freq_meter
  import relax_freq_pkg::*;
#(
  parameter int CLK_REF     = DEF_CLK_REF,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int MIN_EDGES   = DEF_MIN_EDGES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        enabel,
  input  logic        sig_in,
  output logic [31:0] relax_freq,
  output logic        work,
  output logic        freq_valid
);

  localparam int SCALE   = CLK_REF / GATE_CYCLES;
  localparam int W_GATE  = $clog2(GATE_CYCLES);
  localparam int CNT_MAX = GATE_CYCLES / 2;
  localparam int W_CNT   = $clog2(CNT_MAX + 1);
  localparam logic [31:0] SCALE32 = 32'(SCALE);

  if (longint'(SCALE) * longint'(CNT_MAX) > 64'h0000_0000_FFFF_FFFF) begin : g_range_chk
    $error("relax_freq_meter: CNT_MAX*SCALE does not fit in 32 bits");
  end

  logic rise;

  sig_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .sig_in (sig_in),
    .rise_p (rise)
  );

  meter_state_t      state_q, state_d;
  logic [W_GATE-1:0] gate_cnt_q, gate_cnt_d;
  logic [W_CNT-1:0]  edge_cnt_q, edge_cnt_d;
  logic [W_CNT-1:0]  cap_cnt_q, cap_cnt_d;
  logic              cap_vld_q, cap_vld_d;
  logic [31:0]       relax_freq_q, relax_freq_d;
  logic              work_q, work_d;
  logic              freq_valid_q, freq_valid_d;

  logic [W_CNT-1:0]  edge_sum;
  logic              gate_last;
  logic              abort;

  assign edge_sum  = (edge_cnt_q == W_CNT'(CNT_MAX)) ? edge_cnt_q : edge_cnt_q + W_CNT'(rise);
  assign gate_last = (gate_cnt_q == W_GATE'(GATE_CYCLES - 1));
  assign abort     = clk_en && (state_q != IDLE) && !enabel;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    cap_vld_d  = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        IDLE: if (enabel) state_d = ARM;
        ARM: begin
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          state_d    = enabel ? GATE : IDLE;
        end
        GATE: begin
          // the window's final cycle still contributes its edge to the capture
          if (gate_last) begin
            cap_cnt_d  = edge_sum;
            cap_vld_d  = 1'b1;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
          end else begin
            gate_cnt_d = gate_cnt_q + 1'b1;
            edge_cnt_d = edge_sum;
          end
          if (!enabel) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // publish runs on every clk so the strobe completes even while clk_en is low
  always_comb begin
    relax_freq_d = relax_freq_q;
    work_d       = work_q;
    freq_valid_d = cap_vld_q;
    if (cap_vld_q) begin
      relax_freq_d = 32'(cap_cnt_q) * SCALE32;
      work_d       = (32'(cap_cnt_q) >= 32'(MIN_EDGES));
    end else if (abort) begin
      work_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      cap_cnt_q    <= '0;
      cap_vld_q    <= 1'b0;
      relax_freq_q <= '0;
      work_q       <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      cap_cnt_q    <= cap_cnt_d;
      cap_vld_q    <= cap_vld_d;
      relax_freq_q <= relax_freq_d;
      work_q       <= work_d;
      freq_valid_q <= freq_valid_d;
    end
  end

  assign relax_freq = relax_freq_q;
  assign work       = work_q;
  assign freq_valid = freq_valid_q;

endmodule

// File: tb/tb_relax_freq_meter.sv
// Bench for relax_freq_meter with a short 100-cycle gate so windows complete quickly.
module tb_relax_freq_meter;

  localparam int G  = 100;
  localparam int CR = 100_000;
  localparam int SC = CR / G;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en = 1'b0;
  logic        enabel;
  logic        sig_in = 1'b0;
  logic [31:0] relax_freq;
  logic        work;
  logic        freq_valid;

  int checks = 0;
  int errors = 0;
  int half = 0;
  int div  = 1;
  int ph   = 0;
  int cyc  = 0;

  relax_freq_meter #(.CLK_REF(CR), .GATE_CYCLES(G), .MIN_EDGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .enabel     (enabel),
    .sig_in     (sig_in),
    .relax_freq (relax_freq),
    .work       (work),
    .freq_valid (freq_valid)
  );

  always #5 clk = ~clk;

  // square-wave source with half-period `half` clks and a clk_en divider, both off the active edge
  always @(negedge clk) begin
    cyc = cyc + 1;
    clk_en = ((cyc % div) == 0);
    if (half == 0) begin
      sig_in = 1'b0;
      ph = 0;
    end else begin
      ph = ph + 1;
      if (ph >= half) begin
        ph = 0;
        sig_in = ~sig_in;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=[%0d..%0d]", name, act, lo, hi);
    end
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    bit ok;
    ok = 1'b0;
    cycles = 0;
    while (cycles < limit && !ok) begin
      @(posedge clk); #1;
      cycles++;
      if (freq_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_valid_timeout actual=%0d required<%0d", cycles, limit);
    end
  endtask

  task automatic count_pulses(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (freq_valid) pulses++;
    end
  endtask

  typedef struct {
    int half;
    int div;
    int exp_freq;
    bit exp_work;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int gap, pulses, w, t, lo, hi;

    tbl[0] = '{half: 0,  div: 1, exp_freq: 0,     exp_work: 1'b0};
    tbl[1] = '{half: 1,  div: 1, exp_freq: 50000, exp_work: 1'b1};
    tbl[2] = '{half: 2,  div: 1, exp_freq: 25000, exp_work: 1'b1};
    tbl[3] = '{half: 5,  div: 1, exp_freq: 10000, exp_work: 1'b1};
    tbl[4] = '{half: 25, div: 1, exp_freq: 2000,  exp_work: 1'b1};
    tbl[5] = '{half: 50, div: 1, exp_freq: 1000,  exp_work: 1'b0};
    tbl[6] = '{half: 5,  div: 2, exp_freq: 20000, exp_work: 1'b1};
    tbl[7] = '{half: 2,  div: 2, exp_freq: 50000, exp_work: 1'b1};

    reset  = 1'b1;
    enabel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_relax_freq", relax_freq, 0);
    chk("reset_work", work, 0);
    chk("reset_freq_valid", freq_valid, 0);
    reset = 1'b0;

    // each vector: skip two windows to settle, then check value, spacing and strobe width
    for (int i = 0; i < 8; i++) begin
      half   = tbl[i].half;
      div    = tbl[i].div;
      enabel = 1'b1;
      wait_valid(3 * G * div + 20, gap);
      wait_valid(G * div + 20, gap);
      wait_valid(G * div + 20, gap);
      chk($sformatf("vec%0d_relax_freq", i), relax_freq, tbl[i].exp_freq);
      chk($sformatf("vec%0d_work", i), work, tbl[i].exp_work);
      chk($sformatf("vec%0d_gap", i), gap, G * div);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_strobe_width", i), freq_valid, 0);
    end

    // random periodic inputs: a G-cycle window holds floor or ceil of W/T rising edges
    for (int r = 0; r < 6; r++) begin
      div = $urandom_range(1, 2);
      if (div == 2) half = 2 * $urandom_range(1, 20);
      else          half = $urandom_range(2, 40);
      w  = G * div;
      t  = 2 * half;
      lo = w / t;
      hi = (w + t - 1) / t;
      wait_valid(3 * G * div + 20, gap);
      wait_valid(G * div + 20, gap);
      wait_valid(G * div + 20, gap);
      chk($sformatf("rnd%0d_scale", r), relax_freq % SC, 0);
      chk_rng($sformatf("rnd%0d_edges_h%0d_d%0d", r, half, div), relax_freq / SC, lo, hi);
      chk($sformatf("rnd%0d_work", r), work, (relax_freq / SC) >= 2);
    end

    // asynchronous reset mid-window clears outputs without waiting for a clock edge
    half = 3;
    div  = 1;
    wait_valid(3 * G + 20, gap);
    repeat (40) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_relax_freq", relax_freq, 0);
    chk("midreset_work", work, 0);
    chk("midreset_freq_valid", freq_valid, 0);
    enabel = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    count_pulses(3 * G, pulses);
    chk("idle_after_reset_pulses", pulses, 0);

    // abort mid-window: no publish, work drops, value holds
    half   = 5;
    enabel = 1'b1;
    wait_valid(3 * G + 20, gap);
    wait_valid(G + 20, gap);
    chk("pre_abort_relax_freq", relax_freq, 10000);
    chk("pre_abort_work", work, 1);
    repeat (40) @(posedge clk);
    #1;
    enabel = 1'b0;
    count_pulses(3 * G, pulses);
    chk("abort_pulses", pulses, 0);
    chk("abort_work", work, 0);
    chk("abort_relax_freq_hold", relax_freq, 10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
